serv_ext_mdu: RTL and testbench
===============================

// Module: serv_ext_mdu
// PURPOSE
// - Responder end of the serv_top extension interface (valid/funct3/rs1/rs2 -> ready/rd).
// - Implements the RV32M ops selected by funct3, using an iterative radix-2 datapath (32 steps).
// - Sits in the rf_top wrapper beside the core; the extension port pins connect straight to the core.
// PARAMETERS
// - RESET_STRATEGY  "MINI"  "MINI": reset control and datapath regs; "NONE": reset control FSM and o_ready only.
// PORTS
// - clk         in   1   core clock; all state updates on the rising edge
// - i_rst       in   1   reset, asynchronous, active-high
// - i_valid     in   1   request; level, held high by the core until o_ready
// - i_funct3    in   3   op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// - i_rs1       in   32  operand A (dividend / multiplicand); stable while i_valid
// - i_rs2       in   32  operand B (divisor / multiplier); stable while i_valid
// - o_ready     out  1   one-cycle result strobe
// - o_rd        out  32  result; valid when o_ready=1, held until the next acceptance
// BEHAVIOUR
// - Reset: FSM=IDLE, o_ready=0. Under "MINI": o_rd=0 and the acc/operand regs are 0.
// - FSM states: IDLE, CALC, FIX, DONE, HOLD.
//   - IDLE -> CALC on i_valid=1 (acceptance edge). Latch funct3 and operand magnitudes (abs for signed
//     ops: rs1 signed for MUL*/DIV/REM except MULHU/DIVU/REMU; rs2 signed only for MULH/DIV/REM).
//     Latch result sign. Load counter=31.
//   - CALC: one shift-add (mul) or restoring subtract (div) step per cycle. CALC -> FIX when counter==0.
//     Total 32 cycles.
//   - FIX: apply two's-complement sign correction.
//     - Select result: low 32 bits (MUL), high 32 bits (MULH*), quotient, or remainder.
//     - Remainder sign follows dividend; quotient sign is sign(rs1)^sign(rs2).
//     - Write o_rd. FIX -> DONE.
//   - DONE: o_ready=1 for exactly this cycle. DONE -> HOLD.
//   - HOLD: wait for i_valid=0, then -> IDLE.
//     - Prevents a stale valid in the cycle after the strobe from being re-accepted.
//     - If i_valid is already 0 in DONE, HOLD lasts 1 cycle.
// - Latency: o_ready is high in the 34th cycle after the acceptance edge (32 CALC + FIX + DONE).
// - Multiply: 64-bit unsigned product of the magnitudes. Negate the 64-bit result before selecting the half.
// - Div by zero (rs2==0): DIV/DIVU q=32'hFFFFFFFF; REM/REMU r=rs1. Falls out of the restoring algorithm
//   with a zero divisor; FIX must not sign-correct q in this case.
// - Overflow: DIV rs1=32'h80000000, rs2=32'hFFFFFFFF gives q=32'h80000000; REM gives r=0.
// - i_valid rising while not in IDLE is ignored. Operands and funct3 are sampled only at acceptance.
// - i_rst asserted mid-operation: abort immediately to IDLE, o_ready=0, no strobe after release.
// CONFIGURATION
// - SERV_EXT_MDU_EARLY_OUT_EN:
//   - Defined: at acceptance, if rs2==0 (any op) or rs1==0 (MUL*), skip CALC.
//     - Go straight to FIX with the precomputed special result; o_ready comes 2 cycles after acceptance.
//     - All other ops: 34 cycles.
//   - Undefined: every op takes 34 cycles; no zero-detect logic is synthesised.
// TESTING
// - MUL rs1=7, rs2=-3 -> o_rd=32'hFFFFFFEB; o_ready high in the 34th cycle after acceptance, width 1.
// - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIV 0x80000000/-1 -> 0x80000000; REM -> 0. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5
//   (with SERV_EXT_MDU_EARLY_OUT_EN: ready 2 cycles after acceptance).
// - Hold i_valid high 3 cycles past o_ready -> no second strobe. Drop i_valid, reassert next cycle
//   with MUL 3*4 -> o_rd=12.
// - Assert i_rst in CALC cycle 10 -> o_ready stays 0. After release, DIVU 9/3 -> o_rd=3 in 34 cycles.

Source files
------------

// File: rtl/serv_ext_mdu.sv
// serv_ext_mdu: RV32M multiply/divide responder for the serv extension port.
// One radix-2 step per cycle (32 steps), then a sign-fix cycle and a one-cycle
// o_ready strobe. Optional build macro SERV_EXT_MDU_EARLY_OUT_EN lets zero
// operands skip the iterative phase. RESET_STRATEGY "MINI" also resets the
// datapath registers; "NONE" resets only the control FSM and o_ready.
//
// Handshake: the core raises i_valid (a level) with stable i_funct3/i_rs1/i_rs2
// and holds it until it sees o_ready. The request is accepted on the rising edge
// where the FSM is IDLE and i_valid=1. o_ready is high for exactly one cycle
// with o_rd valid; o_rd then holds until the next acceptance. After the strobe
// the block waits for i_valid to drop before it can accept again, so a valid
// that is still high in the cycle after the strobe is never taken as a new
// request.
module serv_ext_mdu #(
    parameter RESET_STRATEGY = "MINI"
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_ready,
    output logic [31:0] o_rd,
    output logic [2:0]  o_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic [2:0]  state;
    logic [4:0]  cnt;

    // Datapath registers. For multiply, {acc, lo} is the shifting product and
    // lo starts as the multiplier; for divide, acc is the partial remainder and
    // lo shifts the dividend out while the quotient bits shift in.
    logic [31:0] acc, acc_nxt;
    logic [31:0] lo, lo_nxt;
    logic [31:0] opb, opb_nxt;
    logic [2:0]  f3, f3_nxt;
    logic        sign_q, sign_q_nxt;
    logic        sign_r, sign_r_nxt;
    logic [31:0] rd_nxt;

    // Operand decode at acceptance.
    logic        a_sgn, b_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        early_zero;

    // Step and result helpers.
    logic [32:0] sum;
    logic [32:0] diff;
    logic [63:0] prod, prod_s;
    logic [31:0] q_s, r_s;

    assign o_state = state;

    // rs1 is unsigned only for MULHU/DIVU/REMU; rs2 is signed only for MULH/DIV/REM.
    assign a_sgn = !(i_funct3 == 3'b011 || i_funct3 == 3'b101 || i_funct3 == 3'b111);
    assign b_sgn = (i_funct3 == 3'b001 || i_funct3 == 3'b100 || i_funct3 == 3'b110);
    assign a_neg = a_sgn & i_rs1[31];
    assign b_neg = b_sgn & i_rs2[31];
    assign a_mag = a_neg ? -i_rs1 : i_rs1;
    assign b_mag = b_neg ? -i_rs2 : i_rs2;

`ifdef SERV_EXT_MDU_EARLY_OUT_EN
    assign early_zero = (i_rs2 == 32'd0) || (!i_funct3[2] && i_rs1 == 32'd0);
`else
    assign early_zero = 1'b0;
`endif

    assign sum  = {1'b0, acc} + (lo[0] ? {1'b0, opb} : 33'd0);
    assign diff = {acc, lo[31]} - {1'b0, opb};

    // Sign correction: the whole 64-bit product is negated before a half is
    // picked; a zero divisor leaves the all-ones quotient uncorrected.
    assign prod   = {acc, lo};
    assign prod_s = sign_q ? -prod : prod;
    assign q_s    = (sign_q && opb != 32'd0) ? -lo : lo;
    assign r_s    = sign_r ? -acc : acc;

    // Control FSM: acceptance, step counter, result strobe and the HOLD guard.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            o_ready <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        cnt   <= 5'd31;
                        state <= early_zero ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt == 5'd0) state <= S_FIX;
                    else             cnt   <= cnt - 5'd1;
                end
                S_FIX: begin
                    state   <= S_DONE;
                    o_ready <= 1'b1;
                end
                S_DONE: state <= S_HOLD;
                S_HOLD: begin
                    if (!i_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath next state: load on acceptance, one step per CALC cycle, result in FIX.
    always_comb begin
        acc_nxt    = acc;
        lo_nxt     = lo;
        opb_nxt    = opb;
        f3_nxt     = f3;
        sign_q_nxt = sign_q;
        sign_r_nxt = sign_r;
        rd_nxt     = o_rd;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    f3_nxt     = i_funct3;
                    sign_q_nxt = a_neg ^ b_neg;
                    sign_r_nxt = a_neg;
                    acc_nxt    = 32'd0;
                    if (i_funct3[2]) begin
                        lo_nxt  = a_mag;
                        opb_nxt = b_mag;
                    end else begin
                        lo_nxt  = b_mag;
                        opb_nxt = a_mag;
                    end
                    // Preload what the iteration would have produced for a zero operand.
                    if (early_zero) begin
                        if (i_funct3[2]) begin
                            lo_nxt  = 32'hFFFF_FFFF;
                            acc_nxt = a_mag;
                            opb_nxt = 32'd0;
                        end else begin
                            lo_nxt  = 32'd0;
                            acc_nxt = 32'd0;
                        end
                    end
                end
            end
            S_CALC: begin
                if (f3[2]) begin
                    if (!diff[32]) begin
                        acc_nxt = diff[31:0];
                        lo_nxt  = {lo[30:0], 1'b1};
                    end else begin
                        acc_nxt = {acc[30:0], lo[31]};
                        lo_nxt  = {lo[30:0], 1'b0};
                    end
                end else begin
                    acc_nxt = sum[32:1];
                    lo_nxt  = {sum[0], lo[31:1]};
                end
            end
            S_FIX: begin
                case (f3)
                    3'b000:                 rd_nxt = prod_s[31:0];
                    3'b001, 3'b010, 3'b011: rd_nxt = prod_s[63:32];
                    3'b100, 3'b101:         rd_nxt = q_s;
                    default:                rd_nxt = r_s;
                endcase
            end
            default: ;
        endcase
    end

    generate
        if (RESET_STRATEGY == "NONE") begin : g_dp_nores
            // Datapath registers without reset.
            always_ff @(posedge clk) begin
                acc    <= acc_nxt;
                lo     <= lo_nxt;
                opb    <= opb_nxt;
                f3     <= f3_nxt;
                sign_q <= sign_q_nxt;
                sign_r <= sign_r_nxt;
                o_rd   <= rd_nxt;
            end
        end else begin : g_dp_rst
            // Datapath registers cleared by reset.
            always_ff @(posedge clk or posedge i_rst) begin
                if (i_rst) begin
                    acc    <= 32'd0;
                    lo     <= 32'd0;
                    opb    <= 32'd0;
                    f3     <= 3'd0;
                    sign_q <= 1'b0;
                    sign_r <= 1'b0;
                    o_rd   <= 32'd0;
                end else begin
                    acc    <= acc_nxt;
                    lo     <= lo_nxt;
                    opb    <= opb_nxt;
                    f3     <= f3_nxt;
                    sign_q <= sign_q_nxt;
                    sign_r <= sign_r_nxt;
                    o_rd   <= rd_nxt;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_serv_ext_mdu.sv
// tb_serv_ext_mdu: directed and random RV32M requests against a plain-arithmetic
// reference model; checks result, strobe latency, strobe width, HOLD behaviour
// and reset abort.
module tb_serv_ext_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2;
    logic        ready;
    logic [31:0] rd;
    logic [2:0]  st;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    serv_ext_mdu dut (
        .clk      (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .i_funct3 (f3),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .o_ready  (ready),
        .o_rd     (rd),
        .o_state  (st)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef SERV_EXT_MDU_EARLY_OUT_EN
        if (b == 32'd0 || (!op[2] && a == 32'd0)) return 2;
`endif
        return 34;
    endfunction

    // Driver: issue one request at a negedge, wait for the strobe, check it,
    // optionally hold valid past the strobe, then leave the block idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int extra, input string tag);
        int n;
        int lat;
        logic [31:0] e;
        lat = exp_lat(op, a, b);
        f3 = op; rs1 = a; rs2 = b; valid = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        n = 1;
        // Operands must have been captured at acceptance.
        rs1 = $urandom; rs2 = $urandom; f3 = 3'($urandom_range(0, 7));
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        e = exp_q.pop_front();
        check({tag, " rd"}, rd, e);
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            check({tag, " no second strobe"}, {31'd0, ready}, 32'd0);
        end
        valid = 1'b0;
        @(negedge clk);
        check({tag, " strobe width"}, {31'd0, ready}, 32'd0);
        check({tag, " rd held"}, rd, e);
        if (extra == 0) @(negedge clk);
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int highs;
        rst = 1'b1; valid = 1'b0; f3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(negedge clk);
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset rd", rd, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul 7*-3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh min*min");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu max*max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu -1*max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem -7/2");
        run_op(3'd5, 32'd100, 32'd7, 0, "divu 100/7");
        run_op(3'd7, 32'd100, 32'd7, 0, "remu 100/7");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div overflow");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem overflow");
        run_op(3'd5, 32'd5, 32'd0, 0, "divu 5/0");
        run_op(3'd7, 32'd5, 32'd0, 0, "remu 5/0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0, "div -7/0");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 0, "rem -7/0");
        run_op(3'd0, 32'd0, 32'd12345, 0, "mul 0*x");

        // Valid held 3 cycles past the strobe, then a fresh request right after the drop.
        run_op(3'd1, 32'd123456, 32'hFFFF_0000, 3, "hold valid");
        run_op(3'd0, 32'd3, 32'd4, 0, "mul 3*4");

        // Reset in CALC cycle 10 aborts the operation with no strobe.
        f3 = 3'd5; rs1 = 32'd1234; rs2 = 32'd7; valid = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        @(negedge clk);
        check("abort ready", {31'd0, ready}, 32'd0);
        check("abort rd", rd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) highs++;
        end
        check("abort no strobe", 32'(highs), 32'd0);
        run_op(3'd5, 32'd9, 32'd3, 0, "divu 9/3 after reset");

        // Random requests with corner-biased operands.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick($urandom_range(0, 7));
            b  = pick($urandom_range(0, 7));
            run_op(op, a, b, $urandom_range(0, 2), $sformatf("rand%0d op%0d", i, op));
        end

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
